audio_mix_scheduler: RTL

//  Time-multiplexed mixer and sequencer for the shared audio_pwm modulator.
//  At each sample frame, scans N voice channels one per clock, sums the enabled samples

---
 rtl/audio_mix_scheduler_if.sv | 41 ++++
 rtl/audio_mix_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/audio_mix_scheduler_if.sv
// Voice-to-modulator bus for audio_mix_scheduler.
//   ch_data      channel samples, channel i at [i*WIDTH +: WIDTH]
//   ch_enable    per-channel mix enable
//   mute         forces the frame result to zero
//   ch_ack       one-cycle pulse when channel i is sampled
//   pwm_data     mixed sample held for the PWM modulator
//   frame_strobe one-cycle pulse when pwm_data is updated
//   clip         pulses with frame_strobe when the mix saturated
// master: voice-generator / PWM side. slave: the scheduler.
interface audio_mix_scheduler_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 6
);
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic [CHANNELS-1:0]       ch_enable;
    logic                      mute;
    logic [CHANNELS-1:0]       ch_ack;
    logic [WIDTH-1:0]          pwm_data;
    logic                      frame_strobe;
    logic                      clip;

    modport master (
        output ch_data,
        output ch_enable,
        output mute,
        input  ch_ack,
        input  pwm_data,
        input  frame_strobe,
        input  clip
    );

    modport slave (
        input  ch_data,
        input  ch_enable,
        input  mute,
        output ch_ack,
        output pwm_data,
        output frame_strobe,
        output clip
    );
endinterface

// File: rtl/audio_mix_scheduler.sv
// Time-multiplexed mixer and sequencer for the shared PWM modulator.
// Once per sample frame (SAMPLE_DIV clocks) the channels are scanned one per clock, enabled
// samples are summed into a wide accumulator, and the saturated result is loaded into the
// PWM data register.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high
//   bus  audio_mix_scheduler_if.slave (ch_data, ch_enable, mute in;
//        ch_ack, pwm_data, frame_strobe, clip out)
// CHANNELS must be a power of two >= 2; SAMPLE_DIV must be >= CHANNELS+2.
module audio_mix_scheduler #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned SAMPLE_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    audio_mix_scheduler_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(CHANNELS);
    // Wide enough that summing every channel at full scale cannot wrap.
    localparam int unsigned AccW = WIDTH + IdxW;
    localparam int unsigned DivW = $clog2(SAMPLE_DIV);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(CHANNELS - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
    localparam logic [AccW-1:0] SatMax  = AccW'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StLoad
    } state_e;

    state_e            state_q;
    logic [DivW-1:0]   div_q;
    logic [IdxW-1:0]   idx_q;
    logic [AccW-1:0]   acc_q;
    logic [WIDTH-1:0]  pwm_q;
    logic              strobe_q;
    logic              clip_q;

    logic [WIDTH-1:0]    cur_sample;
    logic                cur_enable;
    logic                acc_sat;
    logic [CHANNELS-1:0] ack;

    // Free-running frame divider, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (div_q == DivLast) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    // Select the channel addressed by the scan index.
    always_comb begin
        cur_sample = '0;
        cur_enable = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_sample = bus.ch_data[i*WIDTH +: WIDTH];
                cur_enable = bus.ch_enable[i];
            end
        end
    end

    assign acc_sat = (acc_q > SatMax);

    // Sequencer: IDLE waits for the frame tick, SCAN walks the channels, LOAD publishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            acc_q    <= '0;
            pwm_q    <= '0;
            strobe_q <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            clip_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (div_q == '0) begin
                        state_q <= StScan;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                StScan: begin
                    if (cur_enable) begin
                        acc_q <= acc_q + AccW'(cur_sample);
                    end
                    if (idx_q == LastIdx) begin
                        state_q <= StLoad;
                    end
                    // Wraps back to 0 after the last channel.
                    idx_q <= idx_q + IdxW'(1);
                end
                StLoad: begin
                    if (bus.mute) begin
                        pwm_q <= '0;
                    end else if (acc_sat) begin
                        pwm_q <= '1;
                    end else begin
                        pwm_q <= acc_q[WIDTH-1:0];
                    end
                    clip_q   <= !bus.mute && acc_sat;
                    strobe_q <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Ack is decoded from the FSM registers, so it is one-hot (or zero) by construction.
    always_comb begin
        ack = '0;
        if (state_q == StScan) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                ack[i] = (idx_q == IdxW'(i)) && bus.ch_enable[i];
            end
        end
    end

    assign bus.ch_ack       = ack;
    assign bus.pwm_data     = pwm_q;
    assign bus.frame_strobe = strobe_q;
    assign bus.clip         = clip_q;

endmodule
